// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the main-memory responder slice.
//   mem_state_t                 - responder FSM states (IDLE, WAIT, RESP)
//   MEM_LATENCY_DEFAULT         - default access latency in cycles
//   MEM_ADDR_WORDS_LOG2_DEFAULT - default log2 of RAM depth in words
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int unsigned MEM_LATENCY_DEFAULT         = 4;
  localparam int unsigned MEM_ADDR_WORDS_LOG2_DEFAULT = 15;

endpackage

// File: rtl/posted_write_buffer.sv
// posted_write_buffer: one-entry buffer holding an acknowledged write until
// its full access latency has elapsed, then draining it into the RAM.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (empties the buffer)
//   load_i        - capture load_idx_i/load_data_i (only issued when empty)
//   query_idx_i   - word index compared against the buffered entry
//   full_o        - entry held, not yet written to RAM
//   drain_o       - entry is written to RAM at the end of this cycle
//   drain_idx_o   - buffered word index
//   drain_data_o  - buffered write data
//   match_o       - buffer full and query_idx_i equals the buffered index
module posted_write_buffer
  import mem_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IDX_W   = MEM_ADDR_WORDS_LOG2_DEFAULT,
  parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [IDX_W-1:0] load_idx_i,
  input  logic [XLEN-1:0]  load_data_i,
  input  logic [IDX_W-1:0] query_idx_i,
  output logic             full_o,
  output logic             drain_o,
  output logic [IDX_W-1:0] drain_idx_o,
  output logic [XLEN-1:0]  drain_data_o,
  output logic             match_o
);

  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  logic             valid_q;
  logic [CW-1:0]    cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [XLEN-1:0]  data_q;

  // Drain on the same count as the non-posted commit, so the RAM is written
  // exactly LATENCY cycles after the write was accepted.
  assign drain_o      = valid_q && (cnt_q == CW'(1));
  assign full_o       = valid_q;
  assign drain_idx_o  = idx_q;
  assign drain_data_o = data_q;
  assign match_o      = valid_q && (idx_q == query_idx_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      cnt_q   <= CNT_LOAD;
      idx_q   <= load_idx_i;
      data_q  <= load_data_i;
    end else if (drain_o) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (valid_q) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: word-addressed backing RAM for the data cache, serving
// one read or write at a time after a fixed LATENCY (>= 1) cycles.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req_valid   - request present
//   req_we      - 1 = write, 0 = read
//   req_addr    - byte address; word index is req_addr[ADDR_WORDS_LOG2+1:2]
//   req_wdata   - write data
//   req_ready   - request accepted when req_valid && req_ready
//   resp_valid  - one-cycle completion pulse for reads and writes
//   resp_rdata  - read data (0 for write responses), valid with resp_valid
// Build option MAIN_MEM_POSTED_WRITE_EN: adds a one-entry posted write buffer;
// writes are acknowledged one cycle after acceptance and drain later.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned ADDR_WORDS_LOG2 = MEM_ADDR_WORDS_LOG2_DEFAULT,
  parameter int unsigned LATENCY         = MEM_LATENCY_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata
);

  localparam int unsigned IDX_W = ADDR_WORDS_LOG2;
  localparam int unsigned DEPTH = 2 ** ADDR_WORDS_LOG2;
  localparam int unsigned CW    = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  mem_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;

  logic [XLEN-1:0]  mem_q [DEPTH];

  logic             hs;
  logic [IDX_W-1:0] req_idx;
  logic             c_we;
  logic [IDX_W-1:0] c_idx;
  logic [XLEN-1:0]  c_wdata;
  logic             commit;
  logic             posted_wr;
  logic             wr_hold;
  logic             ram_we;
  logic [IDX_W-1:0] ram_widx;
  logic [XLEN-1:0]  ram_wdata;
  logic [XLEN-1:0]  rd_word;
  logic             unused_addr;

  assign hs          = req_valid && req_ready;
  assign req_idx     = req_addr[IDX_W+1:2];
  assign unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

  // With LATENCY = 1 the commit happens on the accepting edge, so the
  // operands come straight from the request instead of the latched copy.
  always_comb begin
    c_we    = we_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    if (state_q == IDLE) begin
      c_we    = req_we;
      c_idx   = req_idx;
      c_wdata = req_wdata;
    end
  end

  assign commit = !rst && ((hs && (LATENCY == 1)) ||
                           ((state_q == WAIT) && (cnt_q == CW'(1))));

`ifdef MAIN_MEM_POSTED_WRITE_EN
  logic             buf_full;
  logic             buf_drain;
  logic             buf_match;
  logic [IDX_W-1:0] buf_idx;
  logic [XLEN-1:0]  buf_data;

  posted_write_buffer #(
    .XLEN    (XLEN),
    .IDX_W   (IDX_W),
    .LATENCY (LATENCY)
  ) u_pwb (
    .clk          (clk),
    .rst          (rst),
    .load_i       (hs && req_we && (LATENCY > 1)),
    .load_idx_i   (req_idx),
    .load_data_i  (req_wdata),
    .query_idx_i  (c_idx),
    .full_o       (buf_full),
    .drain_o      (buf_drain),
    .drain_idx_o  (buf_idx),
    .drain_data_o (buf_data),
    .match_o      (buf_match)
  );

  // Accepted writes always find the buffer empty, so a direct RAM write
  // (LATENCY = 1 only) never coincides with a drain.
  assign posted_wr = req_we;
  assign wr_hold   = req_we && buf_full;
  assign ram_we    = (commit && c_we) || (buf_drain && !rst);
  assign ram_widx  = buf_drain ? buf_idx  : c_idx;
  assign ram_wdata = buf_drain ? buf_data : c_wdata;
  assign rd_word   = buf_match ? buf_data : mem_q[c_idx];
`else
  assign posted_wr = 1'b0;
  assign wr_hold   = 1'b0;
  assign ram_we    = commit && c_we;
  assign ram_widx  = c_idx;
  assign ram_wdata = c_wdata;
  assign rd_word   = mem_q[c_idx];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      if (hs) begin
        we_q    <= req_we;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_widx] <= ram_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          cnt_d   = CNT_LOAD;
          state_d = ((LATENCY == 1) || posted_wr) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is cleared on accept so write responses return 0; a read
  // commit later in the same transaction overrides it.
  always_comb begin
    resp_rdata_d = resp_rdata_q;
    if (hs) begin
      resp_rdata_d = '0;
    end
    if (commit && !c_we) begin
      resp_rdata_d = rd_word;
    end
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == IDLE) && !rst && !wr_hold;
    resp_valid = (state_q == RESP);
    resp_rdata = resp_rdata_q;
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: self-checking bench for main_mem_responder.
// A LATENCY=4 instance gets directed and randomized traffic compared against
// an associative-array memory model; a LATENCY=1 instance checks the
// single-cycle timing.
module tb_main_mem_responder;

  localparam int unsigned AW  = 15;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  logic        r1_req_valid = 1'b0;
  logic        r1_req_we    = 1'b0;
  logic [31:0] r1_req_addr  = '0;
  logic [31:0] r1_req_wdata = '0;
  logic        r1_req_ready;
  logic        r1_resp_valid;
  logic [31:0] r1_resp_rdata;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [31:0] ref_mem [int unsigned];

  main_mem_responder #(.XLEN(32), .ADDR_WORDS_LOG2(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );

  main_mem_responder #(.XLEN(32), .ADDR_WORDS_LOG2(AW), .LATENCY(1)) dut_l1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (r1_req_valid),
    .req_we     (r1_req_we),
    .req_addr   (r1_req_addr),
    .req_wdata  (r1_req_wdata),
    .req_ready  (r1_req_ready),
    .resp_valid (r1_resp_valid),
    .resp_rdata (r1_resp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned key;
    key = 32'(addr[AW+1:2]);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  // One full transaction on the LATENCY=4 instance; acc returns the accept cycle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input string tag, output int unsigned acc);
    int unsigned n;
    int unsigned lat;
    logic [31:0] exp_rd;
    @(negedge clk);
    check({tag, "_idle_rv"}, 32'(resp_valid), 32'h0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) check({tag, "_rdy_timeout"}, 32'h0, 32'h1);
    acc    = cyc;
    exp_rd = we ? 32'h0 : model_read(addr);
    if (we) ref_mem[32'(addr[AW+1:2])] = wd;
    lat = LAT;
`ifdef MAIN_MEM_POSTED_WRITE_EN
    if (we) lat = 1;
`endif
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, cyc - acc, lat);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned a1, a2;
    logic [14:0] pool [8];
    logic [31:0] addr;
    logic        we;
    int unsigned k;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rv", 32'(resp_valid), 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_rdy", 32'(req_ready), 32'h0);
      check("rst_rdy_l1", 32'(r1_req_ready), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 32'(req_ready), 32'h1);
    check("post_rst_rdy_l1", 32'(r1_req_ready), 32'h1);

    // LATENCY=1 instance: write then read of the same word
    r1_req_valid = 1'b1; r1_req_we = 1'b1;
    r1_req_addr  = 32'h10; r1_req_wdata = 32'h5555AAAA;
    @(negedge clk);
    r1_req_valid = 1'b0;
    check("l1_wr_rv", 32'(r1_resp_valid), 32'h1);
    check("l1_wr_rdata", r1_resp_rdata, 32'h0);
    check("l1_wr_rdy_n1", 32'(r1_req_ready), 32'h0);
    @(negedge clk);
    check("l1_rdy_n2", 32'(r1_req_ready), 32'h1);
    check("l1_idle_rv", 32'(r1_resp_valid), 32'h0);
    r1_req_valid = 1'b1; r1_req_we = 1'b0; r1_req_addr = 32'h13;
    @(negedge clk);
    r1_req_valid = 1'b0;
    check("l1_rd_rv", 32'(r1_resp_valid), 32'h1);
    check("l1_rd_rdata", r1_resp_rdata, 32'h5555AAAA);
    check("l1_rd_rdy_n1", 32'(r1_req_ready), 32'h0);
    @(negedge clk);
    check("l1_rd_rdy_n2", 32'(r1_req_ready), 32'h1);
    check("l1_rd_pulse", 32'(r1_resp_valid), 32'h0);

    // Basic write/read with ignored byte offset
    do_req(1'b1, 32'h100, 32'hDEADBEEF, "wr100", a1);
    do_req(1'b0, 32'h102, 32'h0, "rd102", a2);
    // Alias: upper address bits ignored
    do_req(1'b1, 32'h0002_0000, 32'h12345678, "wr_alias", a1);
    do_req(1'b0, 32'h0, 32'h0, "rd_alias", a2);

    // Request spacing
`ifdef MAIN_MEM_POSTED_WRITE_EN
    do_req(1'b1, 32'h80, 32'hA5A5A5A5, "pw", a1);
    do_req(1'b0, 32'h80, 32'h0, "pw_rd", a2);
    check("pw_rd_gap", a2 - a1, 32'd2);
    do_req(1'b1, 32'h84, 32'h00000001, "pw2a", a1);
    do_req(1'b1, 32'h88, 32'h00000002, "pw2b", a2);
    check("pw_hold_gap", a2 - a1, 32'd4);
`else
    do_req(1'b1, 32'h80, 32'hA5A5A5A5, "b2b_wr", a1);
    do_req(1'b0, 32'h80, 32'h0, "b2b_rd", a2);
    check("b2b_gap", a2 - a1, LAT + 1);
`endif

    // Reset during an in-flight write: RAM keeps the prior value
    do_req(1'b1, 32'h40, 32'h0, "pre40", a1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    #1;
    check("abort_rdy", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef MAIN_MEM_POSTED_WRITE_EN
    check("abort_ack", 32'(resp_valid), 32'h1);
`else
    check("abort_ack", 32'(resp_valid), 32'h0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_rv", 32'(resp_valid), 32'h0);
      check("abort_rdy_rst", 32'(req_ready), 32'h0);
      check("abort_rdata", resp_rdata, 32'h0);
    end
    rst = 1'b0;
    do_req(1'b0, 32'h40, 32'h0, "abort_rd40", a2);

    // Randomized traffic over a small aliased pool
    for (int i = 0; i < 8; i++) begin
      pool[i] = 15'($urandom);
      do_req(1'b1, 32'(pool[i]) << 2, $urandom, "init", a1);
    end
    for (int i = 0; i < 40; i++) begin
      k    = $urandom_range(0, 7);
      we   = 1'($urandom);
      addr = ($urandom & 32'hFFFE_0000) | (32'(pool[k]) << 2) | ($urandom & 32'h3);
      do_req(we, addr, $urandom, we ? "rnd_wr" : "rnd_rd", a1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Memory-side responder for the cached RV32 data path. It accepts single-word read and write requests from the data cache: line fills on a miss, and dirty-line writebacks on eviction. Each request is served after a fixed, parameterised access latency, which models main-memory delay. The cache stalls the core on `resp_valid`. The block owns the word-addressed backing RAM and replaces the zero-latency RAM behind the cache.

## Interface
- `XLEN`, 32, data width.
- `ADDR_WORDS_LOG2`, 15, log2 of RAM depth in words (128 KiB).
- `LATENCY`, 4, cycles from request acceptance to `resp_valid`; must be ≥1.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  XLEN  write data.
- `req_ready`  out  1  request accepted this cycle when `req_valid && req_ready`.
- `resp_valid`  out  1  one-cycle completion pulse, for reads and writes.
- `resp_rdata`  out  XLEN  read data; valid only with `resp_valid`.

## Operation
- Word index is `req_addr[ADDR_WORDS_LOG2+1:2]`.
  - `req_addr[1:0]` is ignored; byte merging is done in the cache.
  - Upper bits are ignored, so out-of-range addresses alias modulo the RAM depth.
- FSM states: IDLE, WAIT, RESP.
  - **IDLE:** `req_ready`=1. On handshake, latch `we`, word index and `wdata`; load the latency counter with `LATENCY-1`. Go to WAIT, or directly to RESP when `LATENCY`=1.
  - **WAIT:** `req_ready`=0. Decrement the counter. At 0, commit: a write updates the RAM; a read registers `RAM[idx]` into `resp_rdata`. Go to RESP.
  - **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE.
    - Write response: `resp_rdata`=0.
    - `req_ready`=0 in this state, so back-to-back requests are spaced `LATENCY+1` cycles apart.
- Requests are served in order, one outstanding at a time. `req_*` signals are don't-care outside the handshake cycle.
- RAM contents are not cleared by reset. They are initialised to 0 at time zero in simulation.

## Timing
- Reset values: `req_ready`=0 while `rst`=1; `resp_valid`=0; `resp_rdata`=0; FSM=IDLE; counter=0.
- First accept is possible in the first cycle after `rst` deasserts.
- Handshake at cycle N → `resp_valid` at cycle N+`LATENCY`.
- Write is visible to any read accepted at or after cycle N+`LATENCY`.
- Reset mid-transaction aborts the transaction.
  - An uncommitted write is discarded; the RAM keeps its old value.
  - No `resp_valid` is issued.
- Counter width is `$clog2(LATENCY+1)`; it never wraps.

## Configuration
- `MAIN_MEM_POSTED_WRITE_EN`
- **Defined:** a one-entry posted write buffer is added.
  - A write accepted with the buffer empty is acknowledged at N+1. The buffer holds `{idx, data}`, and the RAM is written at N+`LATENCY`, when the buffer frees.
  - A write arriving while the buffer is full sees `req_ready`=0 until the buffer drains.
  - Reads are accepted while the buffer is full and keep normal latency.
  - At read commit, if the buffer is still full and `idx` matches, `resp_rdata` is forwarded from the buffer.
  - If a read commit and a drain fall in the same cycle, the read returns the buffered data when `idx` matches.
  - Reset empties the buffer without committing it.
- **Undefined:** all writes take the full `LATENCY` path described above.

## Structure
- Package `mem_pkg`:
  - `mem_state_t` enum {IDLE, WAIT, RESP};
  - `MEM_LATENCY_DEFAULT`;
  - `MEM_ADDR_WORDS_LOG2_DEFAULT`.
- Sub-module `posted_write_buffer`: valid flag, index/data registers, drain counter and match output. It is instantiated only under the macro.

## Test plan
- Reset then idle: `resp_valid`=0 and `resp_rdata`=0 during reset; `req_ready`=1 in the cycle after `rst` falls.
- Write `0xDEADBEEF` to `0x100` at cycle N: `resp_valid` at N+4 with `resp_rdata`=0. A later read of `0x102` returns `0xDEADBEEF` at accept+4.
- Alias check: write `0x12345678` to `0x0002_0000`; a read of `0x0` returns `0x12345678`.
- `LATENCY`=1 build: read accepted at N gives `resp_valid` at N+1. `req_ready` is low at N+1 and high at N+2.
- Reset during WAIT of a write of `0xCAFEF00D` to `0x40`: no `resp_valid` pulse. A later read of `0x40` returns the prior value, 0.
- With `MAIN_MEM_POSTED_WRITE_EN`:
  - Write `0xA5A5A5A5` to `0x80` at N gives `resp_valid` at N+1.
  - A read of `0x80` accepted at N+2 returns `0xA5A5A5A5` at N+6.
  - A second write at N+2 is held off by `req_ready`=0 until N+4.
